// File: rtl/cfg_stream_tx.sv
// Streams the elaborated core configuration as a framed, checksummed
// sequence of 32-bit words over a valid/ready link.
package cfg_stream_pkg;

  typedef struct packed {
    logic [31:0] XLEN;
    logic [31:0] MISA;
    logic [31:0] FLEN;
    logic [31:0] PA_BITS;
    logic [63:0] RESET_VECTOR;
    logic        ZICSR_SUPPORTED;
    logic        ZIFENCEI_SUPPORTED;
    logic        ZICNTR_SUPPORTED;
    logic        ZIHPM_SUPPORTED;
    logic        ZFH_SUPPORTED;
    logic        ZFA_SUPPORTED;
    logic        SSTC_SUPPORTED;
    logic        VIRTMEM_SUPPORTED;
    logic        SVADU_SUPPORTED;
    logic        ZMMUL_SUPPORTED;
    logic        ZICBOM_SUPPORTED;
    logic        ZICBOZ_SUPPORTED;
    logic        ZICBOP_SUPPORTED;
    logic        ZICOND_SUPPORTED;
    logic        SVPBMT_SUPPORTED;
    logic        SVNAPOT_SUPPORTED;
    logic        SVINVAL_SUPPORTED;
    logic        ZAAMO_SUPPORTED;
    logic        ZALRSC_SUPPORTED;
    logic        ZBA_SUPPORTED;
    logic        ZBB_SUPPORTED;
    logic        ZBC_SUPPORTED;
    logic        ZBS_SUPPORTED;
    logic        ZCA_SUPPORTED;
    logic        ZCB_SUPPORTED;
    logic        DCACHE_SUPPORTED;
    logic        ICACHE_SUPPORTED;
    logic        BPRED_SUPPORTED;
    logic [31:0] DCACHE_NUMWAYS;
    logic [31:0] ICACHE_NUMWAYS;
    logic [31:0] PMP_ENTRIES;
    logic [31:0] PLIC_NUM_SRC;
    logic [31:0] UART_PRESCALE;
  } cvw_t;

  localparam cvw_t RV64GC_CFG = '{
    XLEN: 32'd64,
    MISA: 32'h0014_112D,
    FLEN: 32'd64,
    PA_BITS: 32'd56,
    RESET_VECTOR: 64'h0000_0012_8000_0000,
    ZICSR_SUPPORTED: 1'b1,
    ZIFENCEI_SUPPORTED: 1'b1,
    ZICNTR_SUPPORTED: 1'b1,
    ZIHPM_SUPPORTED: 1'b1,
    ZFH_SUPPORTED: 1'b0,
    ZFA_SUPPORTED: 1'b1,
    SSTC_SUPPORTED: 1'b1,
    VIRTMEM_SUPPORTED: 1'b1,
    SVADU_SUPPORTED: 1'b1,
    ZMMUL_SUPPORTED: 1'b0,
    ZICBOM_SUPPORTED: 1'b1,
    ZICBOZ_SUPPORTED: 1'b1,
    ZICBOP_SUPPORTED: 1'b0,
    ZICOND_SUPPORTED: 1'b1,
    SVPBMT_SUPPORTED: 1'b1,
    SVNAPOT_SUPPORTED: 1'b0,
    SVINVAL_SUPPORTED: 1'b1,
    ZAAMO_SUPPORTED: 1'b1,
    ZALRSC_SUPPORTED: 1'b1,
    ZBA_SUPPORTED: 1'b1,
    ZBB_SUPPORTED: 1'b1,
    ZBC_SUPPORTED: 1'b0,
    ZBS_SUPPORTED: 1'b1,
    ZCA_SUPPORTED: 1'b1,
    ZCB_SUPPORTED: 1'b1,
    DCACHE_SUPPORTED: 1'b1,
    ICACHE_SUPPORTED: 1'b1,
    BPRED_SUPPORTED: 1'b1,
    DCACHE_NUMWAYS: 32'd4,
    ICACHE_NUMWAYS: 32'd4,
    PMP_ENTRIES: 32'd16,
    PLIC_NUM_SRC: 32'd10,
    UART_PRESCALE: 32'd1
  };

  localparam cvw_t RV32_CFG = '{
    XLEN: 32'd32,
    MISA: 32'h4014_1105,
    FLEN: 32'd32,
    PA_BITS: 32'd34,
    RESET_VECTOR: 64'h0000_0000_8000_0000,
    ZICSR_SUPPORTED: 1'b1,
    ZIFENCEI_SUPPORTED: 1'b1,
    ZICNTR_SUPPORTED: 1'b1,
    ZIHPM_SUPPORTED: 1'b0,
    ZFH_SUPPORTED: 1'b0,
    ZFA_SUPPORTED: 1'b0,
    SSTC_SUPPORTED: 1'b0,
    VIRTMEM_SUPPORTED: 1'b0,
    SVADU_SUPPORTED: 1'b0,
    ZMMUL_SUPPORTED: 1'b1,
    ZICBOM_SUPPORTED: 1'b0,
    ZICBOZ_SUPPORTED: 1'b0,
    ZICBOP_SUPPORTED: 1'b0,
    ZICOND_SUPPORTED: 1'b1,
    SVPBMT_SUPPORTED: 1'b0,
    SVNAPOT_SUPPORTED: 1'b0,
    SVINVAL_SUPPORTED: 1'b0,
    ZAAMO_SUPPORTED: 1'b1,
    ZALRSC_SUPPORTED: 1'b0,
    ZBA_SUPPORTED: 1'b1,
    ZBB_SUPPORTED: 1'b1,
    ZBC_SUPPORTED: 1'b1,
    ZBS_SUPPORTED: 1'b1,
    ZCA_SUPPORTED: 1'b1,
    ZCB_SUPPORTED: 1'b0,
    DCACHE_SUPPORTED: 1'b0,
    ICACHE_SUPPORTED: 1'b1,
    BPRED_SUPPORTED: 1'b0,
    DCACHE_NUMWAYS: 32'd1,
    ICACHE_NUMWAYS: 32'd2,
    PMP_ENTRIES: 32'd0,
    PLIC_NUM_SRC: 32'd53,
    UART_PRESCALE: 32'd3
  };

endpackage

module cfg_stream_tx
  import cfg_stream_pkg::*;
#(
  parameter cvw_t        P     = RV64GC_CFG,
  parameter logic [23:0] MAGIC = 24'h435657
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        Start,
  input  logic        Abort,
  output logic        TxValid,
  input  logic        TxReady,
  output logic [31:0] TxData,
  output logic        TxLast,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    BODY,
    CSUM
  } state_t;

  localparam logic [31:0] FMAP = {
    4'b0,
    P.BPRED_SUPPORTED,
    P.ICACHE_SUPPORTED,
    P.DCACHE_SUPPORTED,
    P.ZCB_SUPPORTED,
    P.ZCA_SUPPORTED,
    P.ZBS_SUPPORTED,
    P.ZBC_SUPPORTED,
    P.ZBB_SUPPORTED,
    P.ZBA_SUPPORTED,
    P.ZALRSC_SUPPORTED,
    P.ZAAMO_SUPPORTED,
    P.SVINVAL_SUPPORTED,
    P.SVNAPOT_SUPPORTED,
    P.SVPBMT_SUPPORTED,
    P.ZICOND_SUPPORTED,
    P.ZICBOP_SUPPORTED,
    P.ZICBOZ_SUPPORTED,
    P.ZICBOM_SUPPORTED,
    P.ZMMUL_SUPPORTED,
    P.SVADU_SUPPORTED,
    P.VIRTMEM_SUPPORTED,
    P.SSTC_SUPPORTED,
    P.ZFA_SUPPORTED,
    P.ZFH_SUPPORTED,
    P.ZIHPM_SUPPORTED,
    P.ZICNTR_SUPPORTED,
    P.ZIFENCEI_SUPPORTED,
    P.ZICSR_SUPPORTED
  };

  localparam logic [31:0] CACHE_W = {
    P.DCACHE_NUMWAYS[7:0],
    P.ICACHE_NUMWAYS[7:0],
    P.PMP_ENTRIES[7:0],
    P.PLIC_NUM_SRC[7:0]
  };

  state_t      state;
  logic [3:0]  idx;
  logic [31:0] acc;
  logic [31:0] acc_nxt;
  logic        hs;

  // Payload words are pure functions of the elaborated config.
  function automatic logic [31:0] word(input logic [3:0] i);
    logic [31:0] w;
    w = '0;
    unique case (i)
      4'd0: w = {MAGIC, 8'd10};
      4'd1: w = P.XLEN;
      4'd2: w = P.MISA;
      4'd3: w = {P.FLEN[15:0], P.PA_BITS[15:0]};
      4'd4: w = P.RESET_VECTOR[31:0];
      4'd5: w = P.RESET_VECTOR[63:32];
      4'd6: w = FMAP;
      4'd7: w = CACHE_W;
      4'd8: w = P.UART_PRESCALE;
      default: w = '0;
    endcase
    return w;
  endfunction

  assign hs      = TxValid & TxReady;
  assign acc_nxt = acc + TxData;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      idx     <= '0;
      acc     <= '0;
      TxValid <= 1'b0;
      TxData  <= '0;
      TxLast  <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (Abort) begin
        state   <= IDLE;
        idx     <= '0;
        acc     <= '0;
        TxValid <= 1'b0;
        TxData  <= '0;
        TxLast  <= 1'b0;
        Busy    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (Start) begin
              state   <= HDR;
              idx     <= '0;
              acc     <= '0;
              TxValid <= 1'b1;
              TxData  <= word(4'd0);
              Busy    <= 1'b1;
            end
          end
          HDR: begin
            if (hs) begin
              state  <= BODY;
              idx    <= 4'd1;
              acc    <= acc_nxt;
              TxData <= word(4'd1);
            end
          end
          BODY: begin
            if (hs) begin
              acc <= acc_nxt;
              // Negated sum makes the whole frame add to zero.
              if (idx == 4'd8) begin
                state  <= CSUM;
                TxData <= ~acc_nxt + 32'd1;
                TxLast <= 1'b1;
              end else begin
                idx    <= idx + 4'd1;
                TxData <= word(idx + 4'd1);
              end
            end
          end
          CSUM: begin
            if (hs) begin
              state   <= IDLE;
              idx     <= '0;
              TxValid <= 1'b0;
              TxData  <= '0;
              TxLast  <= 1'b0;
              Busy    <= 1'b0;
              Done    <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cfg_stream_tx.sv
// Randomized bench for cfg_stream_tx against a word-table reference
// built directly from the configuration struct.
module tb_cfg_stream_tx;
  import cfg_stream_pkg::*;

  typedef logic [31:0] frame_t [0:9];

  logic        clk = 1'b0;
  logic        resetn;
  logic        Start;
  logic        Abort;
  logic        TxReady;
  logic        va, la, ba, da;
  logic        vb, lb, bb, db;
  logic [31:0] dta, dtb;

  int errors = 0;
  int checks = 0;

  frame_t e64, e32;

  always #5 clk = ~clk;

  cfg_stream_tx #(.P(RV64GC_CFG)) u_a (
    .clk(clk), .resetn(resetn), .Start(Start), .Abort(Abort),
    .TxValid(va), .TxReady(TxReady), .TxData(dta),
    .TxLast(la), .Busy(ba), .Done(da)
  );

  cfg_stream_tx #(.P(RV32_CFG)) u_b (
    .clk(clk), .resetn(resetn), .Start(Start), .Abort(Abort),
    .TxValid(vb), .TxReady(TxReady), .TxData(dtb),
    .TxLast(lb), .Busy(bb), .Done(db)
  );

  function automatic void model(input cvw_t c, output frame_t w);
    logic f [0:27];
    logic [31:0] s;
    f = '{c.ZICSR_SUPPORTED, c.ZIFENCEI_SUPPORTED,
          c.ZICNTR_SUPPORTED, c.ZIHPM_SUPPORTED,
          c.ZFH_SUPPORTED, c.ZFA_SUPPORTED,
          c.SSTC_SUPPORTED, c.VIRTMEM_SUPPORTED,
          c.SVADU_SUPPORTED, c.ZMMUL_SUPPORTED,
          c.ZICBOM_SUPPORTED, c.ZICBOZ_SUPPORTED,
          c.ZICBOP_SUPPORTED, c.ZICOND_SUPPORTED,
          c.SVPBMT_SUPPORTED, c.SVNAPOT_SUPPORTED,
          c.SVINVAL_SUPPORTED, c.ZAAMO_SUPPORTED,
          c.ZALRSC_SUPPORTED, c.ZBA_SUPPORTED,
          c.ZBB_SUPPORTED, c.ZBC_SUPPORTED,
          c.ZBS_SUPPORTED, c.ZCA_SUPPORTED,
          c.ZCB_SUPPORTED, c.DCACHE_SUPPORTED,
          c.ICACHE_SUPPORTED, c.BPRED_SUPPORTED};
    w[0] = 32'h435657 * 256 + 10;
    w[1] = c.XLEN;
    w[2] = c.MISA;
    w[3] = c.FLEN[15:0] * 65536 + c.PA_BITS[15:0];
    w[4] = c.RESET_VECTOR[31:0];
    w[5] = c.RESET_VECTOR[63:32];
    w[6] = 0;
    for (int i = 0; i < 28; i++)
      if (f[i]) w[6] = w[6] + (32'd1 << i);
    w[7] = c.DCACHE_NUMWAYS[7:0] * 32'h0100_0000
         + c.ICACHE_NUMWAYS[7:0] * 32'h0001_0000
         + c.PMP_ENTRIES[7:0] * 32'h0000_0100
         + c.PLIC_NUM_SRC[7:0];
    w[8] = c.UART_PRESCALE;
    s = 0;
    for (int i = 0; i < 9; i++) s = s + w[i];
    w[9] = 32'd0 - s;
  endfunction

  // Drives one frame from IDLE; random per-word stalls; optional
  // Start re-pulses while the given word index is on the bus.
  task automatic run_frame(
    input  bit          sel,
    input  int          max_stall,
    input  int          ra,
    input  int          rb,
    output logic [31:0] got[$],
    output int          lastpos[$],
    output int          hold_bad,
    output int          busy_bad,
    output int          done_cyc,
    output bit          timeout
  );
    int          stall;
    int          n;
    bit          held;
    logic [31:0] hd;
    logic        hl;
    logic        v, l, b, dn;
    logic [31:0] d;
    got = {};
    lastpos = {};
    hold_bad = 0;
    busy_bad = 0;
    done_cyc = -1;
    timeout = 1'b1;
    held = 1'b0;
    hd = '0;
    hl = 1'b0;
    stall = int'($urandom_range(0, max_stall));
    Start = 1'b1;
    TxReady = (stall == 0);
    @(posedge clk); #1;
    Start = 1'b0;
    n = 1;
    for (int k = 0; k < 300 && timeout; k++) begin
      Start = (got.size() == ra) || (got.size() == rb);
      TxReady = (stall == 0);
      @(negedge clk);
      v  = sel ? vb : va;
      d  = sel ? dtb : dta;
      l  = sel ? lb : la;
      b  = sel ? bb : ba;
      dn = sel ? db : da;
      if (dn) begin
        done_cyc = n;
        timeout = 1'b0;
        if (b) busy_bad++;
      end else begin
        if (!b) busy_bad++;
        if (v && held && (d !== hd || l !== hl)) hold_bad++;
        if (v && TxReady) begin
          got.push_back(d);
          if (l) lastpos.push_back(got.size() - 1);
          held = 1'b0;
          stall = int'($urandom_range(0, max_stall));
        end else if (v) begin
          held = 1'b1;
          hd = d;
          hl = l;
          if (stall > 0) stall--;
        end
      end
      @(posedge clk); #1;
      n++;
    end
    Start = 1'b0;
    TxReady = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    Start = 1'b0;
    Abort = 1'b0;
    TxReady = 1'b0;
    #12;
    @(negedge clk);
    checks++;
    if ({va, la, ba, da, dta} !== 36'd0) begin
      errors++;
      $display("FAIL reset_a: got v%b l%b b%b d%b data=%h want all 0",
               va, la, ba, da, dta);
    end
    checks++;
    if ({vb, lb, bb, db, dtb} !== 36'd0) begin
      errors++;
      $display("FAIL reset_b: got v%b l%b b%b d%b data=%h want all 0",
               vb, lb, bb, db, dtb);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] got[$];
    int lp[$];
    int hb, bbad, dc;
    bit to;
    logic [31:0] s;
    run_frame(1'b0, 0, -1, -1, got, lp, hb, bbad, dc, to);
    checks++;
    if (to || got.size() != 10) begin
      errors++;
      $display("FAIL basic_len: got %0d words timeout=%0b want 10",
               got.size(), to);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== e64[i]) begin
        errors++;
        $display("FAIL basic_word%0d: got %h want %h", i,
                 (i < got.size()) ? got[i] : 32'hx, e64[i]);
      end
    end
    checks++;
    if (got.size() < 2 || got[0] !== 32'h4356570A || got[1] !== 32'd64) begin
      errors++;
      $display("FAIL basic_hdr: got %h %h want 4356570a 00000040",
               (got.size() > 0) ? got[0] : 32'hx,
               (got.size() > 1) ? got[1] : 32'hx);
    end
    checks++;
    if (lp.size() != 1 || lp[0] != 9) begin
      errors++;
      $display("FAIL basic_last: got %0d last flags first at %0d want one at 9",
               lp.size(), (lp.size() > 0) ? lp[0] : -1);
    end
    s = 0;
    foreach (got[i]) s = s + got[i];
    checks++;
    if (s !== 32'd0) begin
      errors++;
      $display("FAIL basic_sum: got %h want 00000000", s);
    end
    checks++;
    if (dc != 11) begin
      errors++;
      $display("FAIL basic_done_cycle: got %0d want 11", dc);
    end
    checks++;
    if (bbad != 0) begin
      errors++;
      $display("FAIL basic_busy: got %0d bad cycles want 0", bbad);
    end
  endtask

  task automatic test_stall();
    logic [31:0] got[$];
    int lp[$];
    int hb, bbad, dc;
    bit to;
    run_frame(1'b0, 5, -1, -1, got, lp, hb, bbad, dc, to);
    checks++;
    if (to || got.size() != 10) begin
      errors++;
      $display("FAIL stall_len: got %0d words timeout=%0b want 10",
               got.size(), to);
    end
    checks++;
    if (hb != 0) begin
      errors++;
      $display("FAIL stall_hold: got %0d unstable cycles want 0", hb);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== e64[i]) begin
        errors++;
        $display("FAIL stall_word%0d: got %h want %h", i,
                 (i < got.size()) ? got[i] : 32'hx, e64[i]);
      end
    end
    checks++;
    if (lp.size() != 1 || lp[0] != 9 || bbad != 0) begin
      errors++;
      $display("FAIL stall_last_busy: got %0d lasts %0d busy errs want 1 0",
               lp.size(), bbad);
    end
  endtask

  task automatic test_abort();
    logic [31:0] got[$];
    int lp[$];
    int hb, bbad, dc;
    bit to;
    Start = 1'b1;
    Abort = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    Abort = 1'b0;
    @(negedge clk);
    checks++;
    if (va !== 1'b0 || ba !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle_wins: got v%b b%b want 0 0", va, ba);
    end
    @(posedge clk); #1;
    Start = 1'b1;
    TxReady = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    Abort = 1'b1;
    @(negedge clk);
    checks++;
    if (va !== 1'b1 || dta !== e64[4]) begin
      errors++;
      $display("FAIL abort_at_word4: got v%b %h want 1 %h", va, dta, e64[4]);
    end
    @(posedge clk); #1;
    Abort = 1'b0;
    TxReady = 1'b0;
    @(negedge clk);
    checks++;
    if (va !== 1'b0 || ba !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop: got v%b b%b want 0 0", va, ba);
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (da !== 1'b0 || va !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done c%0d: got done%b v%b want 0 0", i, da, va);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    run_frame(1'b0, 2, -1, -1, got, lp, hb, bbad, dc, to);
    checks++;
    if (to || got.size() != 10) begin
      errors++;
      $display("FAIL abort_refr_len: got %0d words want 10", got.size());
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== e64[i]) begin
        errors++;
        $display("FAIL abort_refr_word%0d: got %h want %h", i,
                 (i < got.size()) ? got[i] : 32'hx, e64[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] got[$];
    int lp[$];
    int hb, bbad, dc;
    bit to;
    run_frame(1'b0, 2, 2, 7, got, lp, hb, bbad, dc, to);
    checks++;
    if (to || got.size() != 10) begin
      errors++;
      $display("FAIL restart_len: got %0d words want 10", got.size());
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== e64[i]) begin
        errors++;
        $display("FAIL restart_word%0d: got %h want %h", i,
                 (i < got.size()) ? got[i] : 32'hx, e64[i]);
      end
    end
    TxReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (va !== 1'b0 || ba !== 1'b0) begin
        errors++;
        $display("FAIL restart_queued c%0d: got v%b b%b want 0 0", i, va, ba);
      end
    end
    @(posedge clk); #1;
    TxReady = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] got[$];
    int lp[$];
    int hb, bbad, dc;
    bit to;
    Start = 1'b1;
    TxReady = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if ({va, la, ba, da, dta} !== 36'd0) begin
      errors++;
      $display("FAIL rstmid_async: got v%b l%b b%b d%b data=%h want all 0",
               va, la, ba, da, dta);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (va !== 1'b0 || ba !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: got v%b b%b want 0 0", va, ba);
    end
    @(posedge clk); #1;
    run_frame(1'b0, 1, -1, -1, got, lp, hb, bbad, dc, to);
    checks++;
    if (to || got.size() != 10) begin
      errors++;
      $display("FAIL rstmid_len: got %0d words want 10", got.size());
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== e64[i]) begin
        errors++;
        $display("FAIL rstmid_word%0d: got %h want %h", i,
                 (i < got.size()) ? got[i] : 32'hx, e64[i]);
      end
    end
  endtask

  task automatic test_rv32();
    logic [31:0] got[$];
    int lp[$];
    int hb, bbad, dc;
    bit to;
    logic [31:0] s;
    run_frame(1'b1, 1, -1, -1, got, lp, hb, bbad, dc, to);
    checks++;
    if (to || got.size() != 10 || hb != 0) begin
      errors++;
      $display("FAIL rv32_len: got %0d words hold errs %0d want 10 0",
               got.size(), hb);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== e32[i]) begin
        errors++;
        $display("FAIL rv32_word%0d: got %h want %h", i,
                 (i < got.size()) ? got[i] : 32'hx, e32[i]);
      end
    end
    checks++;
    if (got.size() < 7 || got[4] !== 32'h8000_0000 || got[5] !== 32'd0
        || got[6][7] !== 1'b0) begin
      errors++;
      $display("FAIL rv32_rv_vm: got %h %h %h want 80000000 0 bit7=0",
               (got.size() > 4) ? got[4] : 32'hx,
               (got.size() > 5) ? got[5] : 32'hx,
               (got.size() > 6) ? got[6] : 32'hx);
    end
    s = 0;
    foreach (got[i]) s = s + got[i];
    checks++;
    if (s !== 32'd0 || lp.size() != 1) begin
      errors++;
      $display("FAIL rv32_sum: got %h lasts %0d want 0 1", s, lp.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model(RV64GC_CFG, e64);
    model(RV32_CFG, e32);
    test_reset();
    test_basic();
    test_stall();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    test_rv32();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
